// File: rtl/y86_pkg.sv
// Shared Y86-64 execute-stage constants.
// ALU op encodings and condition-code bit positions.
package y86_pkg;
  localparam int WORD_W = 64;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;
endpackage

// File: rtl/add_sub_64.sv
// 64-bit adder with optional B inversion and carry-in.
// Subtract is a + ~b + 1 on the same chain.
module add_sub_64
  import y86_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              inv_b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);
  logic [WORD_W-1:0] w_b;
  logic [WORD_W:0]   w_full;

  assign w_b    = b ^ {WORD_W{inv_b}};
  assign w_full = {1'b0, a} + {1'b0, w_b}
                + {{WORD_W{1'b0}}, cin};
  assign sum    = w_full[WORD_W-1:0];
  assign cout   = w_full[WORD_W];
endmodule

// File: rtl/alu.sv
// Y86-64 execute ALU: add/sub/and/xor with ZF/SF/OF.
// Result and flags are registered (one cycle latency).
module alu
  import y86_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  input  logic [1:0]        ctrl,
  output logic [WORD_W-1:0] result,
  output logic [2:0]        cond
);
  logic [WORD_W-1:0] w_sum;
  logic              w_cout;
  logic              w_sub;
  logic [WORD_W-1:0] w_r;
  logic              w_of;
  logic [2:0]        w_cc;
  logic [WORD_W-1:0] r_result;
  logic [2:0]        r_cond;

  assign w_sub = (ctrl == ALU_SUB);

  add_sub_64 u_add (
    .a     (A),
    .b     (B),
    .inv_b (w_sub),
    .cin   (w_sub),
    .sum   (w_sum),
    .cout  (w_cout)
  );

  always_comb begin
    w_r  = w_sum;
    w_of = 1'b0;
    unique case (ctrl)
      ALU_ADD: begin
        w_r  = w_sum;
        w_of = (A[63] == B[63]) && (w_sum[63] != A[63]);
      end
      ALU_SUB: begin
        w_r  = w_sum;
        w_of = (A[63] != B[63]) && (w_sum[63] != A[63]);
      end
      ALU_AND: w_r = A & B;
      ALU_XOR: w_r = A ^ B;
      default: w_r = w_sum;
    endcase
  end

  always_comb begin
    w_cc        = 3'b000;
    w_cc[CC_ZF] = (w_r == '0);
    w_cc[CC_SF] = w_r[63];
    w_cc[CC_OF] = w_of;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_result <= '0;
      r_cond   <= 3'b000;
    end else begin
      r_result <= w_r;
      r_cond   <= w_cc;
    end
  end

  assign result = r_result;
  assign cond   = r_cond;

  logic w_unused;
  assign w_unused = w_cout;
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered Y86-64 ALU.
// Each vector is driven before an edge and checked just after it.
module tb_alu;
  logic        clock;
  logic        reset;
  logic [63:0] A;
  logic [63:0] B;
  logic [1:0]  ctrl;
  logic [63:0] result;
  logic [2:0]  cond;

  int total;
  int bad;

  alu dut (
    .clock  (clock),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .ctrl   (ctrl),
    .result (result),
    .cond   (cond)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  op;
    logic [63:0] er;
    logic [2:0]  ec;
  } vec_t;

  localparam int NV = 18;
  vec_t v [NV];

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic check(input string nm,
                       input logic [63:0] er,
                       input logic [2:0]  ec);
    total++;
    if (result !== er || cond !== ec) begin
      bad++;
      $display("FAIL %s: got r=%h c=%b want r=%h c=%b",
               nm, result, cond, er, ec);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    A     = 64'd0;
    B     = 64'd0;
    ctrl  = 2'b00;

    // reset held two cycles, then release
    v[0]  = '{1'b1, 64'd5, 64'd7, 2'b00, 64'd0, 3'b000};
    v[1]  = '{1'b1, 64'd5, 64'd7, 2'b00, 64'd0, 3'b000};
    v[2]  = '{1'b0, 64'd5, 64'd7, 2'b00, 64'd12, 3'b000};
    v[3]  = '{1'b0, MAXP, 64'd1, 2'b00, MINN, 3'b011};
    v[4]  = '{1'b0, 64'd10, 64'd10, 2'b01, 64'd0, 3'b100};
    v[5]  = '{1'b0, 64'd3, 64'd10, 2'b01,
              64'hFFFF_FFFF_FFFF_FFF9, 3'b010};
    v[6]  = '{1'b0, MINN, 64'd1, 2'b01, MAXP, 3'b001};
    v[7]  = '{1'b0, 64'hF0F0, 64'h0FF0, 2'b10,
              64'h00F0, 3'b000};
    v[8]  = '{1'b0, 64'hDEAD, 64'hDEAD, 2'b11, 64'd0, 3'b100};
    v[9]  = '{1'b0, ONES, 64'd0, 2'b11, ONES, 3'b010};
    // back-to-back add, sub, and(under reset), xor
    v[10] = '{1'b0, 64'd100, ONES, 2'b00, 64'd99, 3'b000};
    v[11] = '{1'b0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 2'b01,
              64'd8, 3'b000};
    v[12] = '{1'b1, 64'hFF, 64'h0F, 2'b10, 64'd0, 3'b000};
    v[13] = '{1'b0, 64'h0F, 64'hF0, 2'b11, 64'hFF, 3'b000};
    v[14] = '{1'b0, MINN, MINN, 2'b00, 64'd0, 3'b101};
    v[15] = '{1'b0, MINN, MINN, 2'b00, 64'd0, 3'b101};
    v[16] = '{1'b0, 64'd0, 64'd1, 2'b01, ONES, 3'b010};
    v[17] = '{1'b0, ONES, ONES, 2'b00,
              64'hFFFF_FFFF_FFFF_FFFE, 3'b010};

    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      reset = v[i].rst;
      A     = v[i].a;
      B     = v[i].b;
      ctrl  = v[i].op;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d", i), v[i].er, v[i].ec);
    end

    // inputs changing between edges must not disturb outputs
    @(negedge clock);
    A    = 64'd1;
    B    = 64'd2;
    ctrl = 2'b00;
    #1;
    check("hold_mid", 64'hFFFF_FFFF_FFFF_FFFE, 3'b010);
    @(posedge clock);
    #1;
    check("hold_next", 64'd3, 3'b000);
    @(posedge clock);
    #1;
    check("hold_same", 64'd3, 3'b000);

    // reset mid-stream with nonzero outputs
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_clear", 64'd0, 3'b000);
    @(negedge clock);
    reset = 1'b0;
    A     = 64'd9;
    B     = 64'd4;
    ctrl  = 2'b01;
    @(posedge clock);
    #1;
    check("rst_resume", 64'd5, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
